// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide, one result bit per cycle,
// operating on magnitudes with a single-cycle sign fix-up at the end.
module mul_div_unit #(
   parameter int REG_WIDTH = 32,
   parameter int CNT_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [REG_WIDTH-1:0] op_a,
   input  logic [REG_WIDTH-1:0] op_b,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero,
   output logic [REG_WIDTH-1:0] hi,
   output logic [REG_WIDTH-1:0] lo
);
   localparam int W = REG_WIDTH;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 is_div, res_neg, rem_neg, sa, sb;
   logic [W-1:0]         mag_b, abs_a, abs_b;
   logic [2*W-1:0]       acc, step, fixed;
   logic [W:0]           sum, part, diff;
   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sa    = op[0] & op_a[W-1];
      sb    = op[0] & op_b[W-1];
      abs_a = sa ? -op_a : op_a;
      abs_b = sb ? -op_b : op_b;
      sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mag_b & {W{acc[0]}}};
      part  = {acc[2*W-1:W], acc[W-1]};
      diff  = part - {1'b0, mag_b};
      step  = !is_div ? {sum, acc[W-1:1]}
            : diff[W] ? {part[W-1:0], acc[W-2:0], 1'b0}
            : {diff[W-1:0], acc[W-2:0], 1'b1};
      fixed = !is_div ? (res_neg ? -acc : acc)
            : {rem_neg ? -acc[2*W-1:W] : acc[2*W-1:W], res_neg ? -acc[W-1:0] : acc[W-1:0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         is_div      <= 1'b0;
         res_neg     <= 1'b0;
         rem_neg     <= 1'b0;
         mag_b       <= '0;
         acc         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               is_div  <= op[1];
               res_neg <= sa ^ sb;
               rem_neg <= sa;
               mag_b   <= abs_b;
               acc     <= {{W{1'b0}}, abs_a};
               cnt     <= '0;
               busy    <= 1'b1;
               if (op[1] && op_b == '0) begin
                  hi          <= op_a;
                  lo          <= '1;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state       <= DONE;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= step;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_WIDTH'(W - 1)) state <= FIX;
            end
            FIX: begin
               hi          <= fixed[2*W-1:W];
               lo          <= fixed[W-1:0];
               div_by_zero <= 1'b0;
               done        <= 1'b1;
               state       <= DONE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: random and directed ops checked every cycle against
// an arithmetic model of results and busy/done timing.
module tb_mul_div_unit;
   localparam int W = 32;
   logic         clk = 0, rst = 1, start = 0;
   logic [1:0]   op = 0;
   logic [W-1:0] op_a = 0, op_b = 0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;
   int           checks = 0, errors = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.REG_WIDTH(W), .CNT_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
      longint sx, sy;
      sx = $signed(a);
      sy = $signed(b);
      z  = 1'b0;
      if (o == 2'd0) {h, l} = {32'b0, a} * {32'b0, b};
      else if (o == 2'd1) {h, l} = sx * sy;
      else if (b == '0) begin
         z = 1'b1;
         l = '1;
         h = a;
      end else if (o == 2'd2) begin
         l = a / b;
         h = a % b;
      end else begin
         l = 32'(sx / sy);
         h = 32'(sx % sy);
      end
   endfunction

   // cycle-level model: cyc counts edges; an op accepted at edge N finishes at done_edge
   int           cyc = 0, acc_edge = 0, done_edge = 0, next_ok = 0;
   bit           act = 0;
   logic [W-1:0] p_hi, p_lo, m_hi = 0, m_lo = 0;
   logic         p_dz, m_dz = 0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         act = 0;
         m_hi = '0;
         m_lo = '0;
         m_dz = 0;
         next_ok = cyc + 1;
      end else begin
         if (start && cyc >= next_ok) begin
            model(op, op_a, op_b, p_hi, p_lo, p_dz);
            act = 1;
            acc_edge = cyc;
            done_edge = cyc + ((op[1] && op_b == '0) ? 0 : W + 1);
            next_ok = done_edge + 2;
         end
         if (act && cyc == done_edge) begin
            m_hi = p_hi;
            m_lo = p_lo;
            m_dz = p_dz;
         end
      end
   end

   always @(negedge clk) if (cyc > 0) begin
      chk("busy", busy, act && cyc >= acc_edge && cyc <= done_edge);
      chk("done", done, act && cyc == done_edge);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("div_by_zero", div_by_zero, m_dz);
   end

   task automatic go(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit poke, output int lat);
      lat = -1;
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      op = o;
      op_a = a;
      op_b = b;
      start = 1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         start = poke && i == 5;
         op = 2'($urandom);
         op_a = $urandom;
         op_b = $urandom;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      logic [W-1:0] h, l, a, b;
      logic z;
      logic [1:0] o;
      repeat (3) @(negedge clk);
      rst = 0;
      chk("rst_busy", busy, 0);
      chk("rst_hi", hi, 0);
      model(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, h, l, z);
      chk("model_multu", {h, l}, 64'hFFFFFFFE_00000001);
      model(2'd3, 32'hFFFFFFF9, 32'h2, h, l, z);
      chk("model_div", {h, l}, 64'hFFFFFFFF_FFFFFFFD);
      model(2'd3, 32'h80000000, 32'hFFFFFFFF, h, l, z);
      chk("model_div_ovf", {h, l}, 64'h00000000_80000000);

      go(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, n);
      chk("lat_multu", n, 34);
      chk("multu_res", {hi, lo}, 64'hFFFFFFFE_00000001);
      go(2'd1, 32'hFFFFFFFD, 32'h7, 0, n);
      chk("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      go(2'd3, 32'hFFFFFFF9, 32'h2, 0, n);
      chk("div_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      go(2'd3, 32'h80000000, 32'hFFFFFFFF, 0, n);
      chk("div_ovf_res", {hi, lo}, 64'h00000000_80000000);
      chk("div_ovf_dz", div_by_zero, 0);
      go(2'd2, 32'h64, 32'h0, 0, n);
      chk("lat_dz", n, 1);
      chk("dz_flag", div_by_zero, 1);
      chk("dz_res", {hi, lo}, 64'h00000064_FFFFFFFF);
      go(2'd0, 32'h2, 32'h3, 0, n);
      chk("after_dz_flag", div_by_zero, 0);
      chk("after_dz_res", {hi, lo}, 64'h0000000000000006);
      go(2'd0, 32'd1234, 32'd5678, 1, n);
      chk("poke_lat", n, 34);
      chk("poke_res", {hi, lo}, 64'h0000_0000_006A_E9BC);

      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      op = 2'd0;
      op_a = $urandom;
      op_b = $urandom;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("abort_busy", busy, 0);
      chk("abort_out", {hi, lo}, 64'h0);

      start = 1;
      for (int i = 0; i < 200; i++) begin
         op = 2'($urandom);
         op_a = $urandom;
         op_b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
         @(negedge clk);
      end
      start = 0;

      for (int i = 0; i < 120; i++) begin
         o = 2'($urandom);
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 7) == 0) b = 0;
         if ($urandom_range(0, 15) == 0) begin
            a = 32'h80000000;
            b = 32'hFFFFFFFF;
         end
         if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(0, 15));
         go(o, a, b, i[0], n);
         chk("rand_lat", n, (o[1] && b == 0) ? 1 : 34);
      end
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, giving the operand and result width.
REQ-002 SHALL have parameter CNT_WIDTH, default 6, giving the iteration-counter width; SHALL satisfy 2^CNT_WIDTH > REG_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port op, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 SHALL have port op_a, input, REG_WIDTH bits: multiplicand or dividend.
REQ-008 SHALL have port op_b, input, REG_WIDTH bits: multiplier or divisor.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo become valid.
REQ-011 SHALL have port div_by_zero, output, 1 bit: registered flag for the last completed operation.
REQ-012 SHALL have port hi, output, REG_WIDTH bits: product upper half or remainder.
REQ-013 SHALL have port lo, output, REG_WIDTH bits: product lower half or quotient.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 IDLE, start=1: SHALL latch op, op_a and op_b, clear the counter and go to CALC; start=0 SHALL keep IDLE.
REQ-016 SHALL ignore start and any op/op_a/op_b changes in every state except IDLE.
REQ-017 Signed ops SHALL latch operand magnitudes plus result-sign and remainder-sign bits; unsigned ops SHALL latch operands unchanged.
REQ-018 CALC SHALL run exactly REG_WIDTH cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide; then go to FIX.
REQ-019 FIX SHALL apply two's-complement sign correction in one cycle, then go to DONE.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, with hi, lo and div_by_zero updated on the edge entering DONE; DONE SHALL always go to IDLE.
REQ-021 Latency: with start sampled at edge N, done SHALL be high in cycle N+REG_WIDTH+2, and busy SHALL be high from N+1 through the DONE cycle inclusive.
REQ-022 Multiply: {hi,lo} SHALL equal the full 2*REG_WIDTH-bit product, unsigned or signed per op.
REQ-023 Divide: quotient SHALL truncate toward zero; the remainder sign SHALL follow the dividend; |remainder| < |divisor|.
REQ-024 DIV of most-negative by -1 SHALL give lo = most-negative value and hi = 0, with no flag.
REQ-025 Divisor zero, DIVU or DIV: SHALL skip CALC/FIX, go IDLE->DONE, and set div_by_zero=1, lo=all ones, hi=op_a; latency in that case SHALL be 1 cycle, with done in cycle N+1.
REQ-026 Multiply by zero SHALL use the full latency; div_by_zero SHALL stay 0 for all multiply ops.
REQ-027 Between DONE pulses, hi, lo and div_by_zero SHALL hold their last values.
REQ-028 Intermediate values SHALL never appear on hi or lo.
REQ-029 start in the DONE cycle SHALL be ignored; the earliest new acceptance is the following IDLE cycle.
REQ-030 Back-to-back operations with start held high SHALL start a new operation every REG_WIDTH+3 cycles.

Reset
REQ-031 rst=1 SHALL force IDLE and set busy=0, done=0, div_by_zero=0, hi=0, lo=0, and clear the counter and all internal registers.
REQ-032 rst SHALL take priority over start and over any state, aborting an operation in progress with no done pulse.
REQ-033 After rst deasserts, start SHALL be accepted on the first IDLE edge.

Verification
REQ-034 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at N+34; hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 MULT 0xFFFFFFFD(-3)*0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB(-21).
REQ-036 DIV 0xFFFFFFF9(-7)/0x00000002 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIVU 0x00000064/0 -> done at N+1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x00000064; a following MULTU 2*3 -> div_by_zero=0, hi=0, lo=6.
REQ-038 start a MULTU, change op/op_a and pulse start during CALC -> result uses the original operands with exactly one done; assert rst at cycle N+10 -> busy=0 next cycle, hi=lo=0, no done.
REQ-039 Random signed/unsigned ops against a reference model -> hi/lo match exactly; busy/done timing matches REQ-021 and REQ-025.
